// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback bus of the register file.
// Ports: master = decode/writeback side (drives RegWrite, Rd, Write_data, Rs, Issue_valid, Issue_rd;
// receives Read_data, Busy, Stall, Pending_count); slave = register file (opposite directions).
interface regfile_scoreboard_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(NREGS + 1);
   logic                RegWrite;
   logic [AW-1:0]       Rd;
   logic [XLEN-1:0]     Write_data;
   logic [NRD*AW-1:0]   Rs;
   logic [NRD*XLEN-1:0] Read_data;
   logic                Issue_valid;
   logic [AW-1:0]       Issue_rd;
   logic [NRD-1:0]      Busy;
   logic                Stall;
   logic [CW-1:0]       Pending_count;
   modport master (
      output RegWrite, Rd, Write_data, Rs, Issue_valid, Issue_rd,
      input  Read_data, Busy, Stall, Pending_count
   );
   modport slave (
      input  RegWrite, Rd, Write_data, Rs, Issue_valid, Issue_rd,
      output Read_data, Busy, Stall, Pending_count
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with NRD combinational reads, one write port and a busy scoreboard.
// Ports: clk (rising edge), reset (sync, active-high), bus (regfile_scoreboard_if.slave):
//   RegWrite/Rd/Write_data writeback, Rs/Read_data reads, Issue_valid/Issue_rd reservation,
//   Busy per read port, Stall hazard hold, Pending_count busy register count.
// Option: define REGFILE_BYPASS_EN to forward same-cycle writeback data and released flags to reads/Stall.
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input logic                 clk,
   input logic                 reset,
   regfile_scoreboard_if.slave bus
);
   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(NREGS + 1);
   localparam bit ZR = ZERO_REG != 0;
   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy, busy_vis, busy_nxt;
   logic [NRD-1:0]   rd_busy;
   logic [CW-1:0]    count;
   logic             wr_en, wr_clr, stall, issue_ok;
   assign wr_en = bus.RegWrite && !(ZR && bus.Rd == '0);
`ifdef REGFILE_BYPASS_EN
   // A flag released by this cycle's writeback is already invisible to decode.
   assign busy_vis = busy & ~({NREGS{wr_en}} & (NREGS'(1) << bus.Rd));
`else
   assign busy_vis = busy;
`endif
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] rs;
      assign rs = bus.Rs[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign bus.Read_data[i*XLEN +: XLEN] = wr_en && rs == bus.Rd ? bus.Write_data : regs[rs];
`else
      assign bus.Read_data[i*XLEN +: XLEN] = regs[rs];
`endif
      assign rd_busy[i] = busy_vis[rs];
   end
   assign bus.Busy          = rd_busy;
   assign stall             = |rd_busy || (bus.Issue_valid && busy_vis[bus.Issue_rd]);
   assign bus.Stall         = stall;
   assign issue_ok          = bus.Issue_valid && !stall && !(ZR && bus.Issue_rd == '0);
   assign wr_clr            = wr_en && busy[bus.Rd];
   assign bus.Pending_count = count;
   // Issue is applied after writeback so a same-register pair leaves the flag set.
   always_comb begin
      busy_nxt = busy;
      if (wr_en) busy_nxt[bus.Rd] = 1'b0;
      if (issue_ok) busy_nxt[bus.Issue_rd] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         busy  <= '0;
         count <= '0;
         for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      end else begin
         busy  <= busy_nxt;
         count <= count + CW'(issue_ok) - CW'(wr_clr);
         if (wr_en) regs[bus.Rd] <= bus.Write_data;
      end
   end
endmodule
